// File: rtl/ip_irq_ctrl.sv
// ip_irq_ctrl: interrupt controller fed by the APB peripheral wrapper's
// irq vector. Latches per-source pending bits, with a per-source enable and
// an edge/level type. Drives one registered interrupt line to the CPU.
// The CPU reaches it through a native-memory (nmi) slave port.
//
// Register map (offset = addr & ADDR_MASK):
//   0x00 PEND   RO/W1C  edge bits latched, level bits read live src_s
//   0x04 ENA    RW      per-source enable
//   0x08 TYPE   RW      1 = edge, 0 = level
//   0x0C CLAIM  RO      id+1 of the lowest enabled pending source, 0 if none;
//                       the read clears that source's edge pend
//   0x10 RAW    RO      synchronized sources
//
// Ports:
//   clk_i      system clock
//   rst_n_i    asynchronous active-low reset
//   nmi_valid  access request, held by the master until nmi_ready
//   nmi_addr   byte address; only the ADDR_MASK bits are decoded
//   nmi_wdata  write data
//   nmi_wstrb  byte strobes; any bit set makes the access a write
//   nmi_rdata  registered read data, valid while nmi_ready is high
//   nmi_ready  one-cycle acknowledge, one cycle after valid is accepted
//   irq_src_i  raw source interrupts, active-high
//   irq_o      registered interrupt request to the CPU
//
// FSM states:
//   state  | meaning
//   S_IDLE | waiting for nmi_valid; the access is performed on accept
//   S_ACK  | nmi_ready high for one cycle with the registered rdata

module ip_irq_ctrl #(
    parameter int          IRQ_NUM     = 6,
    parameter int          SYNC_STAGES = 0,
    parameter logic [31:0] ADDR_MASK   = 32'h0000_001F
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               nmi_valid,
    input  logic [31:0]        nmi_addr,
    input  logic [31:0]        nmi_wdata,
    input  logic [3:0]         nmi_wstrb,
    output logic [31:0]        nmi_rdata,
    output logic               nmi_ready,
    input  logic [IRQ_NUM-1:0] irq_src_i,
    output logic               irq_o
);

    localparam logic [31:0] OFF_PEND  = 32'h00;
    localparam logic [31:0] OFF_ENA   = 32'h04;
    localparam logic [31:0] OFF_TYPE  = 32'h08;
    localparam logic [31:0] OFF_CLAIM = 32'h0C;
    localparam logic [31:0] OFF_RAW   = 32'h10;

    typedef enum logic {S_IDLE, S_ACK} state_t;

    state_t state_q, state_n;

    logic [IRQ_NUM-1:0] src_s, src_d, rise;
    logic [IRQ_NUM-1:0] pend_q, pend_n;
    logic [IRQ_NUM-1:0] ena_q, ena_n;
    logic [IRQ_NUM-1:0] type_q, type_n;
    logic [IRQ_NUM-1:0] eff_pend, active, claim_oh, clr;
    logic [5:0]         claim_id;
    logic               claim_found;
    logic [31:0]        off, rd_val, rdata_q;
    logic               acc, wr, claim_rd;
    logic               irq_d;
    logic               unused_wdata;

    // Input synchronizer (bypassed when SYNC_STAGES == 0)
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign src_s = irq_src_i;
        end else begin : g_sync
            logic [IRQ_NUM-1:0] sync_q [SYNC_STAGES];
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
                end else begin
                    sync_q[0] <= irq_src_i;
                    for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
                end
            end
            assign src_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) src_d <= '0;
        else          src_d <= src_s;
    end

    assign rise     = src_s & ~src_d;
    assign eff_pend = (type_q & pend_q) | (~type_q & src_s);
    assign active   = eff_pend & ena_q;

    // Lowest-index enabled pending source wins the claim
    always_comb begin
        claim_id    = '0;
        claim_oh    = '0;
        claim_found = 1'b0;
        for (int i = 0; i < IRQ_NUM; i++) begin
            if (!claim_found && active[i]) begin
                claim_found = 1'b1;
                claim_id    = 6'(i + 1);
                claim_oh[i] = 1'b1;
            end
        end
    end

    // Access decode
    assign off      = nmi_addr & ADDR_MASK;
    assign acc      = (state_q == S_IDLE) && nmi_valid;
    assign wr       = acc && (|nmi_wstrb);
    assign claim_rd = acc && !(|nmi_wstrb) && (off == OFF_CLAIM);

    assign unused_wdata = ^nmi_wdata;

    always_comb begin
        rd_val = '0;
        case (off)
            OFF_PEND:  rd_val[IRQ_NUM-1:0] = eff_pend;
            OFF_ENA:   rd_val[IRQ_NUM-1:0] = ena_q;
            OFF_TYPE:  rd_val[IRQ_NUM-1:0] = type_q;
            OFF_CLAIM: rd_val[5:0]         = claim_id;
            OFF_RAW:   rd_val[IRQ_NUM-1:0] = src_s;
            default:   rd_val = '0;
        endcase
    end

    // Register next values. A rise is OR-ed in after the clear so it wins
    // over a same-cycle W1C or claim; masking with the next TYPE drops the
    // latched pend of any source switched to level.
    always_comb begin
        ena_n  = ena_q;
        type_n = type_q;
        clr    = '0;
        if (wr && off == OFF_ENA)  ena_n  = nmi_wdata[IRQ_NUM-1:0];
        if (wr && off == OFF_TYPE) type_n = nmi_wdata[IRQ_NUM-1:0];
        if (wr && off == OFF_PEND) clr    = nmi_wdata[IRQ_NUM-1:0];
        if (claim_rd)              clr    = claim_oh;
        pend_n = ((pend_q & ~clr) | rise) & type_n;
    end

    // The rise term is folded in so an edge reaches irq_o one cycle after
    // it appears on src_s, rather than waiting for PEND to latch first.
    assign irq_d = |((((pend_q | rise) & type_q) | (src_s & ~type_q)) & ena_q);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pend_q  <= '0;
            ena_q   <= '0;
            type_q  <= '0;
            rdata_q <= '0;
            irq_o   <= 1'b0;
        end else begin
            pend_q <= pend_n;
            ena_q  <= ena_n;
            type_q <= type_n;
            irq_o  <= irq_d;
            if (acc) rdata_q <= rd_val;
        end
    end

    // Handshake FSM
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= S_IDLE;
        else          state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            S_IDLE:  if (nmi_valid) state_n = S_ACK;
            S_ACK:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    assign nmi_ready = (state_q == S_ACK);
    assign nmi_rdata = rdata_q;

endmodule

// File: tb/tb_ip_irq_ctrl.sv
module tb_ip_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        nmi_valid;
    logic [31:0] nmi_addr;
    logic [31:0] nmi_wdata;
    logic [3:0]  nmi_wstrb;
    logic [31:0] nmi_rdata;
    logic        nmi_ready;
    logic [5:0]  irq_src;
    logic        irq_o;

    always #5 clk = ~clk;

    ip_irq_ctrl #(
        .IRQ_NUM    (6),
        .SYNC_STAGES(0),
        .ADDR_MASK  (32'h0000_001F)
    ) dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .nmi_valid(nmi_valid),
        .nmi_addr (nmi_addr),
        .nmi_wdata(nmi_wdata),
        .nmi_wstrb(nmi_wstrb),
        .nmi_rdata(nmi_rdata),
        .nmi_ready(nmi_ready),
        .irq_src_i(irq_src),
        .irq_o    (irq_o)
    );

    typedef struct {
        bit          chk;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic check(input bit ok, input string name,
                         input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Monitor: every acknowledge pops one expected response
    always @(negedge clk) begin
        if (rst_n && nmi_ready) begin
            if (sb_q.size() == 0) begin
                check(1'b0, "unexpected ready", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.chk)
                    check(nmi_rdata === mon_e.exp, mon_e.name, nmi_rdata, mon_e.exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic [31:0] addr, input logic [31:0] wdata,
                       input bit wr, input logic [31:0] exp, input bit chk,
                       input string name, input bit src_en = 1'b0,
                       input logic [5:0] src_val = 6'h00);
        int cyc = 0;
        tick();
        nmi_valid = 1'b1;
        nmi_addr  = addr;
        nmi_wdata = wdata;
        nmi_wstrb = wr ? 4'hF : 4'h0;
        if (src_en) irq_src = src_val;
        sb_q.push_back('{chk, exp, name});
        do begin
            tick();
            cyc++;
        end while (!nmi_ready && cyc < 8);
        nmi_valid = 1'b0;
        nmi_wstrb = 4'h0;
        check(cyc == 1, {name, " latency"}, 32'(cyc), 32'd1);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
        bus(addr, 32'h0, 1'b0, exp, 1'b1, name);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        bus(addr, data, 1'b1, 32'h0, 1'b0, "write");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        nmi_valid = 1'b0;
        nmi_addr  = '0;
        nmi_wdata = '0;
        nmi_wstrb = '0;
        irq_src   = '0;

        // Reset state
        repeat (3) tick();
        check(irq_o === 1'b0, "reset irq_o", 32'(irq_o), 32'd0);
        check(nmi_ready === 1'b0, "reset ready", 32'(nmi_ready), 32'd0);
        rst_n = 1'b1;
        tick();
        rd(32'h00, 32'h0, "rst PEND");
        rd(32'h04, 32'h0, "rst ENA");
        rd(32'h08, 32'h0, "rst TYPE");
        rd(32'h0C, 32'h0, "rst CLAIM");
        rd(32'h10, 32'h0, "rst RAW");

        // Edge source 0
        wr(32'h08, 32'h01);
        wr(32'h04, 32'h01);
        tick();
        irq_src = 6'h01;
        tick();
        check(irq_o === 1'b1, "edge irq_o", 32'(irq_o), 32'd1);
        irq_src = 6'h00;
        rd(32'h00, 32'h01, "edge PEND");
        rd(32'h0C, 32'h01, "edge CLAIM");
        tick();
        check(irq_o === 1'b0, "claim drops irq_o", 32'(irq_o), 32'd0);
        rd(32'h00, 32'h00, "PEND after claim");

        // Level source 2
        wr(32'h08, 32'h00);
        wr(32'h04, 32'h04);
        irq_src = 6'h04;
        tick();
        tick();
        check(irq_o === 1'b1, "level irq_o", 32'(irq_o), 32'd1);
        rd(32'h0C, 32'h03, "level CLAIM 1");
        rd(32'h0C, 32'h03, "level CLAIM 2");
        rd(32'h00, 32'h04, "level PEND live");
        rd(32'h10, 32'h04, "level RAW");
        check(irq_o === 1'b1, "level irq_o held", 32'(irq_o), 32'd1);
        irq_src = 6'h00;
        tick();
        check(irq_o === 1'b0, "level drop irq_o", 32'(irq_o), 32'd0);

        // Priority between sources 1 and 4
        wr(32'h08, 32'h12);
        wr(32'h04, 32'h12);
        irq_src = 6'h12;
        tick();
        irq_src = 6'h00;
        tick();
        check(irq_o === 1'b1, "prio irq_o", 32'(irq_o), 32'd1);
        rd(32'h00, 32'h12, "prio PEND");
        rd(32'h0C, 32'h02, "prio CLAIM src1");
        rd(32'h0C, 32'h05, "prio CLAIM src4");
        rd(32'h0C, 32'h00, "prio CLAIM none");
        tick();
        check(irq_o === 1'b0, "prio irq_o drop", 32'(irq_o), 32'd0);

        // W1C and rise collision on source 3
        wr(32'h08, 32'h08);
        wr(32'h04, 32'h08);
        irq_src = 6'h08;
        tick();
        irq_src = 6'h00;
        tick();
        rd(32'h00, 32'h08, "col PEND set");
        bus(32'h00, 32'h08, 1'b1, 32'h0, 1'b0, "w1c");
        rd(32'h00, 32'h00, "w1c clears PEND");
        bus(32'h00, 32'h08, 1'b1, 32'h0, 1'b0, "w1c with rise", 1'b1, 6'h08);
        irq_src = 6'h00;
        rd(32'h00, 32'h08, "collision PEND");
        rd(32'h14, 32'h00, "unmapped offset");
        check(irq_o === 1'b1, "collision irq_o", 32'(irq_o), 32'd1);

        // Reset during the acknowledge cycle
        tick();
        nmi_valid = 1'b1;
        nmi_addr  = 32'h04;
        nmi_wstrb = 4'h0;
        tick();
        check(nmi_ready === 1'b1, "mid ack ready", 32'(nmi_ready), 32'd1);
        rst_n = 1'b0;
        #1;
        check(nmi_ready === 1'b0, "mid rst ready", 32'(nmi_ready), 32'd0);
        check(irq_o === 1'b0, "mid rst irq_o", 32'(irq_o), 32'd0);
        nmi_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        rd(32'h00, 32'h00, "post rst PEND");
        rd(32'h04, 32'h00, "post rst ENA");
        rd(32'h08, 32'h00, "post rst TYPE");
        check(irq_o === 1'b0, "post rst irq_o", 32'(irq_o), 32'd0);

        tick();
        check(sb_q.size() == 0, "scoreboard drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
